// File: rtl/next_memory.sv
// Unified rv32i instruction/data memory: word-wide RAM with one synchronous write and one
// registered read port, plus GPIO / UART data / UART CSR registers mapped above the RAM.
module next_memory #(
    parameter int              ADDR_W        = 16,
    parameter int              DATA_W        = 32,
    parameter int              RAM_WORDS     = 2048,
    parameter logic [ADDR_W-1:0] GPIO_ADDR     = 16'hFF00,
    parameter logic [ADDR_W-1:0] UART_IO_ADDR  = 16'hFF04,
    parameter logic [ADDR_W-1:0] UART_CSR_ADDR = 16'hFF08,
    parameter                  INIT_FILE     = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] io_gpio_io_reg,
    output logic [DATA_W-1:0] io_uart_io_reg,
    output logic [DATA_W-1:0] io_uart_csr_reg
);

    localparam int WIDX_W = ADDR_W - 2;
    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_GPIO,
        TGT_UART_IO,
        TGT_UART_CSR,
        TGT_NONE
    } target_e;

    typedef struct packed {
        target_e           tgt;
        logic [RAM_AW-1:0] idx;
    } decode_t;

    // Only the word index matters; byte-offset bits are ignored on both ports.
    function automatic decode_t decode(input logic [WIDX_W-1:0] widx);
        decode_t d;
        d.idx = widx[RAM_AW-1:0];
        if (32'(widx) < RAM_WORDS)                    d.tgt = TGT_RAM;
        else if (widx == GPIO_ADDR[ADDR_W-1:2])       d.tgt = TGT_GPIO;
        else if (widx == UART_IO_ADDR[ADDR_W-1:2])    d.tgt = TGT_UART_IO;
        else if (widx == UART_CSR_ADDR[ADDR_W-1:2])   d.tgt = TGT_UART_CSR;
        else                                          d.tgt = TGT_NONE;
        return d;
    endfunction

    logic [DATA_W-1:0] mem [RAM_WORDS];
    decode_t wdec, rdec;
    logic    unused_lsbs;

    assign wdec        = decode(waddr[ADDR_W-1:2]);
    assign rdec        = decode(raddr[ADDR_W-1:2]);
    assign unused_lsbs = ^{waddr[1:0], raddr[1:0]};

    // Power-up image: all-zero.
    initial begin
        for (int i = 0; i < RAM_WORDS; i++) mem[i] = '0;
    end

    // RAM contents survive reset; only the write is gated while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && wen && wdec.tgt == TGT_RAM)
            mem[wdec.idx] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_gpio_io_reg  <= '0;
            io_uart_io_reg  <= '0;
            io_uart_csr_reg <= '0;
        end else if (wen) begin
            case (wdec.tgt)
                TGT_GPIO:     io_gpio_io_reg  <= wdata;
                TGT_UART_IO:  io_uart_io_reg  <= wdata;
                TGT_UART_CSR: io_uart_csr_reg <= wdata;
                default:      ;
            endcase
        end
    end

    // Non-blocking reads of mem and the I/O registers give read-first on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            case (rdec.tgt)
                TGT_RAM:      rdata <= mem[rdec.idx];
                TGT_GPIO:     rdata <= io_gpio_io_reg;
                TGT_UART_IO:  rdata <= io_uart_io_reg;
                TGT_UART_CSR: rdata <= io_uart_csr_reg;
                default:      rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_next_memory.sv
// Bench for next_memory: directed scenarios followed by random traffic, all checked
// against an array-based memory-map model.
module tb_next_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen, ren;
    logic [15:0] waddr, raddr;
    logic [31:0] wdata;
    logic [31:0] rdata, io_gpio_io_reg, io_uart_io_reg, io_uart_csr_reg;

    int checks   = 0;
    int failures = 0;

    // Reference state.
    logic [31:0] m_ram [2048];
    logic [31:0] m_gpio, m_uio, m_csr, m_rd;

    next_memory dut (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren),
        .waddr(waddr), .raddr(raddr), .wdata(wdata), .rdata(rdata),
        .io_gpio_io_reg(io_gpio_io_reg), .io_uart_io_reg(io_uart_io_reg),
        .io_uart_csr_reg(io_uart_csr_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [15:0] a);
        int w = int'(a) / 4;
        if (w < 2048)                  return m_ram[w];
        if (w == int'(16'hFF00) / 4)   return m_gpio;
        if (w == int'(16'hFF04) / 4)   return m_uio;
        if (w == int'(16'hFF08) / 4)   return m_csr;
        return 32'h0;
    endfunction

    task automatic m_write(input logic [15:0] a, input logic [31:0] d);
        int w = int'(a) / 4;
        if (w < 2048)                  m_ram[w] = d;
        else if (w == int'(16'hFF00) / 4) m_gpio = d;
        else if (w == int'(16'hFF04) / 4) m_uio  = d;
        else if (w == int'(16'hFF08) / 4) m_csr  = d;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdata"}, rdata, m_rd);
        chk({tag, ".gpio"},  io_gpio_io_reg,  m_gpio);
        chk({tag, ".uio"},   io_uart_io_reg,  m_uio);
        chk({tag, ".csr"},   io_uart_csr_reg, m_csr);
    endtask

    // One clock: drive, take the edge, update the model (read before write), then compare.
    task automatic cycle(input string tag, input logic we, input logic [15:0] wa,
                         input logic [31:0] wd, input logic re, input logic [15:0] ra);
        wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
        @(posedge clk); #1;
        if (!rst) begin
            if (re) m_rd = m_read(ra);
            if (we) m_write(wa, wd);
        end
        check_all(tag);
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2: a = 16'(($urandom_range(0, 15)) * 4);
            3:       a = 16'h1FFC;
            4:       a = 16'h2000;
            5:       a = 16'hFF00;
            6:       a = 16'hFF04;
            7:       a = 16'hFF08;
            8:       a = 16'hFF0C;
            default: a = 16'($urandom);
        endcase
        a[1:0] = 2'($urandom);
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) m_ram[i] = 32'h0;
        m_gpio = 0; m_uio = 0; m_csr = 0; m_rd = 0;
        rst = 1'b1; wen = 0; ren = 0; waddr = 0; raddr = 0; wdata = 0;

        // Reset holds outputs at zero and ignores traffic.
        #2;
        check_all("reset");
        cycle("reset_wr_ignored", 1'b1, 16'hFF00, 32'h1234, 1'b1, 16'h0000);
        #3 rst = 1'b0;

        cycle("rd_ram0",     1'b0, 16'h0, 32'h0, 1'b1, 16'h0000);
        cycle("wr_0200",     1'b1, 16'h0200, 32'd99, 1'b0, 16'h0000);
        cycle("rd_0200",     1'b0, 16'h0, 32'h0, 1'b1, 16'h0200);
        cycle("rd_0000",     1'b0, 16'h0, 32'h0, 1'b1, 16'h0000);
        cycle("collide",     1'b1, 16'h0200, 32'd5, 1'b1, 16'h0200);
        chk("collide_old", rdata, 32'd99);
        cycle("after_coll",  1'b0, 16'h0, 32'h0, 1'b1, 16'h0200);
        chk("collide_new", rdata, 32'd5);
        cycle("restore",     1'b1, 16'h0200, 32'd99, 1'b0, 16'h0);

        cycle("wr_gpio",     1'b1, 16'hFF00, 32'hA5, 1'b0, 16'h0);
        cycle("wr_uio",      1'b1, 16'hFF04, 32'h41, 1'b1, 16'hFF00);
        cycle("wr_csr",      1'b1, 16'hFF08, 32'h3,  1'b1, 16'hFF04);
        cycle("rd_csr",      1'b0, 16'h0, 32'h0, 1'b1, 16'hFF08);
        chk("csr_readback", rdata, 32'h3);
        cycle("io_collide",  1'b1, 16'hFF00, 32'h5A, 1'b1, 16'hFF00);

        cycle("wr_unmapped", 1'b1, 16'h8000, 32'hDEAD, 1'b1, 16'h8000);
        cycle("rd_unmapped", 1'b0, 16'h0, 32'h0, 1'b1, 16'h8000);
        cycle("hold",        1'b0, 16'h0, 32'h0, 1'b0, 16'h0200);

        // Async reset between edges: outputs clear before any clock.
        cycle("pre_rst",     1'b0, 16'h0, 32'h0, 1'b1, 16'hFF00);
        #1 rst = 1'b1; #1;
        m_gpio = 0; m_uio = 0; m_csr = 0; m_rd = 0;
        check_all("async_rst");
        @(negedge clk) rst = 1'b0;
        #4;
        cycle("rd_after_rst", 1'b0, 16'h0, 32'h0, 1'b1, 16'h0200);
        chk("ram_retained", rdata, 32'd99);

        for (int n = 0; n < 400; n++) begin
            cycle("rand", 1'($urandom), pick_addr(), $urandom,
                  1'($urandom), pick_addr());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
